// File: rtl/struct_byte_tx.sv
// ---------------------------------------------------------------------------
// struct_byte_tx
//
// Transmit end of the record byte-stream link. Accepts one 24-bit packed
// record per valid/ready handshake and serializes it onto an 8-bit
// valid/ready stream in field order:
//   byte0 = field1 (in_rec[23:16])
//   byte1 = field2[15:8]
//   byte2 = field2[7:0]
//   byte3 = byte0 ^ byte1 ^ byte2   (only when STRUCT_BYTE_TX_CHECKSUM_EN)
// out_last marks the final byte of each frame, and frame_cnt counts fully
// transmitted frames, wrapping at 2^CNT_W.
//
// Compile-time option:
//   STRUCT_BYTE_TX_CHECKSUM_EN  - when defined, appends the XOR checksum
//                                 byte (4-byte frames). When undefined,
//                                 frames are 3 bytes and no checksum logic
//                                 is built.
//
// Parameters:
//   CNT_W      width of the completed-frame counter
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream record valid
//   in_ready   transmitter can accept a record this cycle (combinational)
//   in_rec     packed record {field1[7:0], field2[15:0]}
//   out_valid  out_byte holds a valid byte
//   out_ready  downstream accepts the byte this cycle
//   out_byte   current byte (registered)
//   out_last   current byte ends the frame (registered)
//   frame_cnt  number of completed frames (wrapping)
// ---------------------------------------------------------------------------
module struct_byte_tx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_rec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

`ifdef STRUCT_BYTE_TX_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    state_t             state, state_d;
    logic [23:0]        hold_rec, hold_rec_d;
    logic [1:0]         idx, idx_d;
    logic [7:0]         out_byte_d;
    logic               out_last_d;
    logic [CNT_W-1:0]   frame_cnt_d;
    logic               out_xfer;
    logic               accept;
    logic [1:0]         idx_next;

    // Selects the frame byte at position i of a record. Position 3 only
    // exists when the checksum byte is compiled in.
    function automatic logic [7:0] pick_byte(input logic [23:0] rec,
                                             input logic [1:0]  i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            2'd0:    b = rec[23:16];
            2'd1:    b = rec[15:8];
            2'd2:    b = rec[7:0];
            default: begin
`ifdef STRUCT_BYTE_TX_CHECKSUM_EN
                b = rec[23:16] ^ rec[15:8] ^ rec[7:0];
`else
                b = 8'h00;
`endif
            end
        endcase
        return b;
    endfunction

    // A frame is held exactly while in SEND, so out_valid follows the state
    // register and drops asynchronously with reset.
    assign out_valid = (state == SEND);
    assign out_xfer  = out_valid && out_ready;

    // A new record may be taken either when idle or on the very cycle the
    // last byte of the current frame leaves, which removes any gap between
    // back-to-back frames.
    assign in_ready  = (state == IDLE) || (out_xfer && out_last);
    assign accept    = in_valid && in_ready;
    assign idx_next  = idx + 2'd1;

    // Next-state and next-output logic. Acceptance is evaluated after the
    // byte-transfer branch so a same-cycle accept overrides the return to
    // IDLE and loads byte0 of the new record.
    always_comb begin
        state_d     = state;
        hold_rec_d  = hold_rec;
        idx_d       = idx;
        out_byte_d  = out_byte;
        out_last_d  = out_last;
        frame_cnt_d = frame_cnt;

        if (out_xfer) begin
            if (out_last) begin
                frame_cnt_d = frame_cnt + CNT_W'(1);
                state_d     = IDLE;
            end else begin
                idx_d      = idx_next;
                out_byte_d = pick_byte(hold_rec, idx_next);
                out_last_d = (idx_next == LAST_IDX);
            end
        end

        if (accept) begin
            state_d    = SEND;
            hold_rec_d = in_rec;
            idx_d      = 2'd0;
            out_byte_d = in_rec[23:16];
            out_last_d = 1'b0;
        end
    end

    // State and output registers. Reset aborts any frame in flight and
    // clears the frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_rec  <= 24'h000000;
            idx       <= 2'd0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_d;
            hold_rec  <= hold_rec_d;
            idx       <= idx_d;
            out_byte  <= out_byte_d;
            out_last  <= out_last_d;
            frame_cnt <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_struct_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_struct_byte_tx
//
// Self-checking bench for struct_byte_tx (instantiated with CNT_W=2 so the
// counter wrap is reachable). A negedge monitor keeps a queue of expected
// {last, byte} entries pushed at each record acceptance and popped on each
// byte transfer, and checks out_valid, in_ready, out_byte, out_last and
// frame_cnt every cycle. Hand-written sequences compare the captured byte
// stream against literal constants.
// ---------------------------------------------------------------------------
module tb_struct_byte_tx;

`ifdef STRUCT_BYTE_TX_CHECKSUM_EN
    localparam int N = 4;
`else
    localparam int N = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_rec = 24'h000000;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [1:0]  frame_cnt;

    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic [8:0]  exp_q[$];
    logic [7:0]  seen[$];
    logic [1:0]  exp_cnt = 2'd0;
    logic        exp_ready;
    logic [7:0]  ready_pat = 8'hFF;
    logic [2:0]  pat_pos = 3'd0;

    typedef struct {
        logic [23:0] rec;
        logic [7:0]  ready_pat;
        bit          keep;
    } vec_t;

    struct_byte_tx #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rec    (in_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Downstream readiness follows a cyclic 8-bit pattern, LSB first.
    always @(posedge clk) begin
        #1;
        out_ready = ready_pat[pat_pos];
        pat_pos   = pat_pos + 3'd1;
    end

    function automatic logic [31:0] frame_of(input logic [23:0] r);
        return {r, r[23:16] ^ r[15:8] ^ r[7:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor, sampling midway between rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 2'd0;
        end else begin
            checkOutput("frame_cnt", {30'd0, frame_cnt}, {30'd0, exp_cnt});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            exp_ready = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            if (exp_q.size() != 0) begin
                checkOutput("out_byte", {24'd0, out_byte}, {24'd0, exp_q[0][7:0]});
                checkOutput("out_last", {31'd0, out_last}, {31'd0, exp_q[0][8]});
                if (out_ready) begin
                    seen.push_back(out_byte);
                    if (exp_q[0][8]) exp_cnt = exp_cnt + 2'd1;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && exp_ready) begin
                logic [31:0] f;
                f = frame_of(in_rec);
                for (int i = 0; i < N; i++)
                    exp_q.push_back({(i == N - 1), f[31 - 8 * i -: 8]});
            end
        end
    end

    // Presents a record and holds it until accepted. With keep set, in_valid
    // stays high so the caller can chain the next record without a gap.
    task automatic applyStimulus(input logic [23:0] rec, input bit keep);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_rec   = rec;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Keeps in_valid high while scrambling in_rec every cycle until the
    // transmitter accepts; the in-flight frame must be unaffected.
    task automatic churnAccept();
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            in_rec = 24'($urandom);
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("churn_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #2;
            if (!out_valid && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitSeen(input int n);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #2;
            if (seen.size() >= n) done = 1'b1;
        end
        if (!done) checkOutput("seen_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkStream(input string name, input logic [7:0] e[$]);
        checkOutput({name, "_len"}, 32'(seen.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < seen.size(); i++)
            checkOutput(name, {24'd0, seen[i]}, {24'd0, e[i]});
    endtask

    initial begin
        vec_t        vecs[7];
        logic [7:0]  e[$];
        int          wrap_exp[5];

        vecs[0] = '{rec: 24'hA51234, ready_pat: 8'hFF, keep: 1'b0};
        vecs[1] = '{rec: 24'hA51234, ready_pat: 8'h99, keep: 1'b0};
        vecs[2] = '{rec: 24'h010203, ready_pat: 8'hFF, keep: 1'b1};
        vecs[3] = '{rec: 24'hFFEEDD, ready_pat: 8'hFF, keep: 1'b0};
        vecs[4] = '{rec: 24'h3C5A96, ready_pat: 8'h6D, keep: 1'b1};
        vecs[5] = '{rec: 24'h000000, ready_pat: 8'hAA, keep: 1'b1};
        vecs[6] = '{rec: 24'hFFFFFF, ready_pat: 8'h55, keep: 1'b0};
        wrap_exp = '{1, 2, 3, 0, 1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_byte", {24'd0, out_byte}, 32'd0);
        checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
        checkOutput("rst_frame_cnt", {30'd0, frame_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Single frame, downstream always ready
        seen.delete();
        applyStimulus(24'hA51234, 1'b0);
        waitIdle();
`ifdef STRUCT_BYTE_TX_CHECKSUM_EN
        e = '{8'hA5, 8'h12, 8'h34, 8'h83};
`else
        e = '{8'hA5, 8'h12, 8'h34};
`endif
        checkStream("single", e);
        checkOutput("single_cnt", {30'd0, frame_cnt}, 32'd1);

        // Backpressure 1,0,0,1,...
        seen.delete();
        ready_pat = 8'h99;
        applyStimulus(24'hA51234, 1'b0);
        waitIdle();
        checkStream("backpressure", e);

        // Back-to-back frames
        seen.delete();
        ready_pat = 8'hFF;
        applyStimulus(24'h010203, 1'b1);
        applyStimulus(24'hFFEEDD, 1'b0);
        waitIdle();
`ifdef STRUCT_BYTE_TX_CHECKSUM_EN
        e = '{8'h01, 8'h02, 8'h03, 8'h00, 8'hFF, 8'hEE, 8'hDD, 8'hCC};
`else
        e = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hEE, 8'hDD};
`endif
        checkStream("b2b", e);

        // Record changes while busy are ignored until the last-byte cycle
        ready_pat = 8'h99;
        applyStimulus(24'hA51234, 1'b1);
        churnAccept();
        waitIdle();

        // Table-driven vectors under assorted readiness patterns
        for (int v = 0; v < 7; v++) begin
            ready_pat = vecs[v].ready_pat;
            applyStimulus(vecs[v].rec, vecs[v].keep);
        end
        waitIdle();

        // Reset mid-frame after byte1 has transferred
        ready_pat = 8'hFF;
        seen.delete();
        applyStimulus(24'hA51234, 1'b0);
        waitSeen(2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_frame_cnt", {30'd0, frame_cnt}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen.delete();
        applyStimulus(24'h112233, 1'b0);
        waitIdle();
`ifdef STRUCT_BYTE_TX_CHECKSUM_EN
        e = '{8'h11, 8'h22, 8'h33, 8'h00};
`else
        e = '{8'h11, 8'h22, 8'h33};
`endif
        checkStream("after_abort", e);
        checkOutput("after_abort_cnt", {30'd0, frame_cnt}, 32'd1);

        // Counter wrap with a 2-bit counter
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int f = 0; f < 5; f++) begin
            applyStimulus(24'(f * 24'h030507 + 24'h102030), 1'b0);
            waitIdle();
            checkOutput("wrap_cnt", {30'd0, frame_cnt}, 32'(wrap_exp[f]));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
